// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, runtime data width, framing/overrun flags and
// a first-word-fall-through receive FIFO. Optional parity via UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [15:0]       BaudDiv,
  input  logic [3:0]        NBits,
  input  logic              RxEn,
  input  logic              Rx,
  input  logic              RdEn,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]        ParityMode,
  output logic              ParityErr,
`endif
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  output logic [ADDR_W:0]   Count,
  output logic              RxDone,
  output logic              FrameErr,
  output logic              Overrun,
  input  logic              ErrClr,
  output logic [2:0]        StateDbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam logic [3:0]      DATA_W4 = 4'(DATA_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  // Rx synchroniser; both flops reset to the idle (high) line level.
  logic rxMeta, rxSync;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= Rx;
      rxSync <= rxMeta;
    end
  end

  // Free-running oversample tick; BaudDiv of 0 behaves as 1.
  logic [15:0] tickCnt, divM1;
  logic        tick;

  assign divM1 = (BaudDiv == 16'd0) ? 16'd0 : BaudDiv - 16'd1;
  assign tick  = (tickCnt >= divM1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) tickCnt <= '0;
    else     tickCnt <= tick ? '0 : tickCnt + 16'd1;
  end

  // Receive FSM and its datapath registers.
  state_t            state, stateNxt;
  logic [3:0]        st, stNxt;
  logic [3:0]        bitIdx, bitIdxNxt;
  logic [3:0]        nBitsLat, nBitsNxt, nBitsEff;
  logic [DATA_W-1:0] shiftReg, shiftNxt, rxWord;
  logic              pushReq, frameErrSet, parOn, parBadNow;
`ifdef UART_RX_PARITY_EN
  logic [1:0]        parMode, parModeNxt;
  logic              parBad, parBadNxt, parErrSet;
`endif

  assign nBitsEff = (NBits < 4'd5 || NBits > DATA_W4) ? DATA_W4 : NBits;
  // Bits arrive LSB-first into the top of shiftReg; right-justify by the latched width.
  assign rxWord   = shiftReg >> (DATA_W4 - nBitsLat);

`ifdef UART_RX_PARITY_EN
  assign parOn     = parMode[0] ^ parMode[1];
  assign parBadNow = parBad;
`else
  assign parOn     = 1'b0;
  assign parBadNow = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      st       <= '0;
      bitIdx   <= '0;
      nBitsLat <= DATA_W4;
      shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
      parMode  <= 2'b00;
      parBad   <= 1'b0;
`endif
    end else begin
      state    <= stateNxt;
      st       <= stNxt;
      bitIdx   <= bitIdxNxt;
      nBitsLat <= nBitsNxt;
      shiftReg <= shiftNxt;
`ifdef UART_RX_PARITY_EN
      parMode  <= parModeNxt;
      parBad   <= parBadNxt;
`endif
    end
  end

  always_comb begin
    stateNxt    = state;
    stNxt       = st;
    bitIdxNxt   = bitIdx;
    nBitsNxt    = nBitsLat;
    shiftNxt    = shiftReg;
    pushReq     = 1'b0;
    frameErrSet = 1'b0;
`ifdef UART_RX_PARITY_EN
    parModeNxt  = parMode;
    parBadNxt   = parBad;
    parErrSet   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (RxEn && !rxSync) begin
          stateNxt = START;
          stNxt    = '0;
          nBitsNxt = nBitsEff;
`ifdef UART_RX_PARITY_EN
          parModeNxt = ParityMode;
          parBadNxt  = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (st == 4'd7) begin
            stNxt     = '0;
            bitIdxNxt = '0;
            stateNxt  = rxSync ? IDLE : DATA;
          end else begin
            stNxt = st + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          stNxt = st + 4'd1;
          if (st == 4'd15) begin
            shiftNxt  = {rxSync, shiftReg[DATA_W-1:1]};
            bitIdxNxt = bitIdx + 4'd1;
            if (bitIdx == nBitsLat - 4'd1) begin
`ifdef UART_RX_PARITY_EN
              stateNxt = parOn ? PARITY : STOP;
`else
              stateNxt = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          stNxt = st + 4'd1;
          if (st == 4'd15) begin
            stateNxt = STOP;
            // Even mode wants total ones even, odd mode wants it odd.
            if (((^rxWord) ^ rxSync) != parMode[1]) begin
              parBadNxt = 1'b1;
              parErrSet = 1'b1;
            end
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          stNxt = st + 4'd1;
          if (st == 4'd15) begin
            if (rxSync) begin
              pushReq  = !parBadNow;
              stateNxt = IDLE;
            end else begin
              frameErrSet = 1'b1;
              stateNxt    = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rxSync) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign StateDbg = state;
  assign RxDone   = pushReq;

  // Consumer handshake: RxData holds the FIFO head while RxValid is high; a cycle
  // with RdEn=1 and RxValid=1 pops it, RdEn while RxValid=0 does nothing.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic              full, doPop, doPush, dropWord;

  assign full     = (Count == DEPTH_C);
  assign doPop    = RdEn && RxValid;
  assign doPush   = pushReq && (!full || doPop);
  assign dropWord = pushReq && full && !doPop;
  assign RxValid  = (Count != '0);
  assign RxData   = RxValid ? mem[rdPtr] : '0;

  always_ff @(posedge Clk) begin
    if (doPush) mem[wrPtr] <= rxWord;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      Count <= Count + {{ADDR_W{1'b0}}, doPush} - {{ADDR_W{1'b0}}, doPop};
    end
  end

  // Sticky flags: a set event takes priority over ErrClr.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      FrameErr <= frameErrSet | (FrameErr & ~ErrClr);
      Overrun  <= dropWord | (Overrun & ~ErrClr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) ParityErr <= 1'b0;
    else     ParityErr <= parErrSet | (ParityErr & ~ErrClr);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 reception, width handling, FIFO fill and
// overrun, framing error/break, glitch rejection, reset mid-frame, optional parity.
module tb_uart_rx_fifo;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int BIT_CLK = 64;
  localparam int S_IDLE  = 0;
  localparam int S_BREAK = 5;

  logic              Clk, Rst;
  logic [15:0]       BaudDiv;
  logic [3:0]        NBits;
  logic              RxEn, Rx, RdEn, ErrClr;
  logic [DATA_W-1:0] RxData;
  logic              RxValid, RxDone, FrameErr, Overrun;
  logic [ADDR_W:0]   Count;
  logic [2:0]        StateDbg;
`ifdef UART_RX_PARITY_EN
  logic [1:0]        ParityMode;
  logic              ParityErr;
`endif

  uart_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(16), .ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Rst(Rst), .BaudDiv(BaudDiv), .NBits(NBits), .RxEn(RxEn), .Rx(Rx),
    .RdEn(RdEn),
`ifdef UART_RX_PARITY_EN
    .ParityMode(ParityMode), .ParityErr(ParityErr),
`endif
    .RxData(RxData), .RxValid(RxValid), .Count(Count), .RxDone(RxDone),
    .FrameErr(FrameErr), .Overrun(Overrun), .ErrClr(ErrClr), .StateDbg(StateDbg)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // RxDone monitor: counts pulses and records Count on the pulse and one cycle later.
  int              doneCnt = 0;
  logic [ADDR_W:0] preCnt  = '0;
  logic [ADDR_W:0] postCnt = '0;
  bit              grabNext = 1'b0;

  always @(negedge Clk) begin
    if (grabNext) postCnt = Count;
    grabNext = RxDone;
    if (RxDone) begin
      doneCnt++;
      preCnt = Count;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic bit_out(input logic v);
    Rx = v;
    repeat (BIT_CLK) @(negedge Clk);
  endtask

  task automatic send_frame(input int nb, input logic [15:0] data, input bit hasPar,
                            input bit par, input bit stopV);
    bit_out(1'b0);
    for (int i = 0; i < nb; i++) bit_out(data[i]);
    if (hasPar) bit_out(par);
    bit_out(stopV);
    if (stopV) begin
      Rx = 1'b1;
      repeat (16) @(negedge Clk);
    end
  endtask

  task automatic pop();
    RdEn = 1'b1;
    @(negedge Clk);
    RdEn = 1'b0;
  endtask

  task automatic err_clr();
    ErrClr = 1'b1;
    @(negedge Clk);
    ErrClr = 1'b0;
  endtask

  int d0;

  initial begin
    Rst = 1'b1; Rx = 1'b1; RdEn = 1'b0; ErrClr = 1'b0; RxEn = 1'b1;
    BaudDiv = 16'd4; NBits = 4'd8;
`ifdef UART_RX_PARITY_EN
    ParityMode = 2'b00;
`endif
    repeat (3) @(negedge Clk);
    chk("rst_valid", RxValid, 0);
    chk("rst_count", Count, 0);
    chk("rst_done", RxDone, 0);
    chk("rst_data", RxData, 0);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    chk("rst_ferr", FrameErr, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_state", StateDbg, S_IDLE);

    // 0xA5 8N1
    d0 = doneCnt;
    send_frame(8, 16'hA5, 0, 0, 1);
    chk("a5_done", doneCnt - d0, 1);
    chk("a5_pre_cnt", preCnt, 0);
    chk("a5_post_cnt", postCnt, 1);
    chk("a5_valid", RxValid, 1);
    chk("a5_count", Count, 1);
    chk("a5_data", RxData, 8'hA5);
    pop();
    chk("a5_pop_valid", RxValid, 0);
    chk("a5_pop_count", Count, 0);

    // 5-bit frame, then out-of-range width falls back to 8
    NBits = 4'd5;
    send_frame(5, 16'h13, 0, 0, 1);
    chk("nb5_data", RxData, 8'h13);
    pop();
    NBits = 4'd12;
    send_frame(8, 16'hC3, 0, 0, 1);
    chk("nb12_data", RxData, 8'hC3);
    chk("nb12_count", Count, 1);
    pop();
    NBits = 4'd8;

    // Fill past capacity
    for (int i = 0; i < 17; i++) send_frame(8, 16'(i), 0, 0, 1);
    chk("full_count", Count, 16);
    chk("full_ovr", Overrun, 1);
    chk("full_ferr", FrameErr, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), RxData, i);
      pop();
    end
    chk("drain_valid", RxValid, 0);
    chk("drain_count", Count, 0);
    err_clr();
    chk("ovr_clr", Overrun, 0);

    // Stop bit low, line held low three bit-times
    d0 = doneCnt;
    send_frame(8, 16'h55, 0, 0, 0);
    Rx = 1'b0;
    repeat (3 * BIT_CLK) @(negedge Clk);
    chk("ferr_set", FrameErr, 1);
    chk("ferr_count", Count, 0);
    chk("ferr_nodone", doneCnt - d0, 0);
    chk("ferr_break", StateDbg, S_BREAK);
    Rx = 1'b1;
    repeat (20) @(negedge Clk);
    chk("ferr_idle", StateDbg, S_IDLE);
    send_frame(8, 16'h3C, 0, 0, 1);
    chk("after_brk_data", RxData, 8'h3C);
    chk("after_brk_count", Count, 1);
    err_clr();
    chk("ferr_clr", FrameErr, 0);

    // Short glitch on the line is rejected
    d0 = doneCnt;
    Rx = 1'b0;
    repeat (16) @(negedge Clk);
    Rx = 1'b1;
    repeat (BIT_CLK) @(negedge Clk);
    chk("glitch_nodone", doneCnt - d0, 0);
    chk("glitch_ferr", FrameErr, 0);
    chk("glitch_ovr", Overrun, 0);
    chk("glitch_state", StateDbg, S_IDLE);
    chk("glitch_count", Count, 1);

    // Reset in the middle of a frame flushes the FIFO
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    Rst = 1'b1;
    Rx  = 1'b1;
    @(negedge Clk);
    chk("midrst_count", Count, 0);
    chk("midrst_state", StateDbg, S_IDLE);
    chk("midrst_valid", RxValid, 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(negedge Clk);
    d0 = doneCnt;
    send_frame(8, 16'h81, 0, 0, 1);
    chk("post_rst_done", doneCnt - d0, 1);
    chk("post_rst_data", RxData, 8'h81);
    chk("post_rst_count", Count, 1);
    pop();

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x07 has three ones, so parity bit 0 is correct
    ParityMode = 2'b10;
    send_frame(8, 16'h07, 1, 0, 1);
    chk("par_ok_data", RxData, 8'h07);
    chk("par_ok_count", Count, 1);
    chk("par_ok_err", ParityErr, 0);
    pop();
    d0 = doneCnt;
    send_frame(8, 16'h07, 1, 1, 1);
    chk("par_bad_err", ParityErr, 1);
    chk("par_bad_count", Count, 0);
    chk("par_bad_nodone", doneCnt - d0, 0);
    err_clr();
    chk("par_clr", ParityErr, 0);
    ParityMode = 2'b00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
